// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package fetch_pkg;

  // Canonical bubble word (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fault cause reported alongside each response.
  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_MISALIGN = 2'd1,
    FLT_RANGE    = 2'd2
  } fault_e;

  // Responder control state: one BOOT cycle after reset, then RUN.
  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/imem_sram.sv
// Single-clock instruction RAM: one synchronous read port with enable and
// one synchronous write port. A read and a write to the same word in the
// same cycle return the previous contents.
module imem_sram #(
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rd_en,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [DATA_W-1:0]        o_rd_data,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write and enabled read share an edge; the non-blocking read sees old data.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      rd_data_q <= mem[i_rd_addr];
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: rtl/instr_fetch_resp.sv
// Instruction-fetch responder: accepts the PC each cycle, reads the
// instruction RAM one cycle later, and presents instruction/PC/valid/fault
// to the IF/ID boundary with stall hold and redirect bubbles.
module instr_fetch_resp
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter logic [31:0] NOP         = NOP_INSTR
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [31:0]                    i_pc,
  input  logic                           i_stall,
  input  logic                           i_flush,
  input  logic                           i_ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_ld_addr,
  input  logic [31:0]                    i_ld_data,
  output logic [31:0]                    o_instr,
  output logic [31:0]                    o_pc,
  output logic                           o_valid,
  output logic [1:0]                     o_fault,
  output logic [31:0]                    o_fetch_cnt
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Misalignment outranks range; range compares the full word index.
  function automatic fault_e classify(input logic [31:0] pc);
    if (pc[1:0] != 2'b00) begin
      return FLT_MISALIGN;
    end
    if ({2'b00, pc[31:2]} >= 32'(DEPTH_WORDS)) begin
      return FLT_RANGE;
    end
    return FLT_NONE;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  fault_e      fault_q, fault_d;
  logic        use_ram_q, use_ram_d;
  logic [31:0] cnt_q, cnt_d;

  fault_e      pc_fault;
  logic        accept;
  logic        rd_en;
  logic [31:0] ram_rdata;

  assign pc_fault = classify(i_pc);
  // Flush outranks stall; nothing is accepted while booting.
  assign accept   = (state_q == ST_RUN) && !i_stall && !i_flush;
  // The RAM only reads for a clean accept, so a stall leaves its output intact.
  assign rd_en    = accept && (pc_fault == FLT_NONE);

  // Next-state and response-register update; defaults hold everything.
  always_comb begin
    state_d   = ST_RUN;
    pc_d      = pc_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    use_ram_d = use_ram_q;
    cnt_d     = cnt_q;
    if (state_q == ST_RUN) begin
      if (i_flush) begin
        pc_d      = i_pc;
        valid_d   = 1'b0;
        fault_d   = FLT_NONE;
        use_ram_d = 1'b0;
      end else if (!i_stall) begin
        pc_d      = i_pc;
        valid_d   = 1'b1;
        fault_d   = pc_fault;
        use_ram_d = (pc_fault == FLT_NONE);
        if (pc_fault == FLT_NONE) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    end
  end

  // Control and response registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= ST_BOOT;
      pc_q      <= 32'd0;
      valid_q   <= 1'b0;
      fault_q   <= FLT_NONE;
      use_ram_q <= 1'b0;
      cnt_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
      use_ram_q <= use_ram_d;
      cnt_q     <= cnt_d;
    end
  end

  imem_sram #(
    .DEPTH  (DEPTH_WORDS),
    .DATA_W (32)
  ) u_imem (
    .i_clk     (i_clk),
    .i_rd_en   (rd_en),
    .i_rd_addr (i_pc[AW+1:2]),
    .o_rd_data (ram_rdata),
    .i_wr_en   (i_ld_en),
    .i_wr_addr (i_ld_addr),
    .i_wr_data (i_ld_data)
  );

  // RAM data is shown only for a clean fetch; bubbles, faults and reset show NOP.
  assign o_instr     = use_ram_q ? ram_rdata : NOP;
  assign o_pc        = pc_q;
  assign o_valid     = valid_q;
  assign o_fault     = fault_q;
  assign o_fetch_cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch_resp.sv
// Scoreboard bench for instr_fetch_resp: a behavioural model predicts each
// response when stimulus is driven; the expectation is popped and compared
// one edge later.
module tb_instr_fetch_resp;

  localparam int          DEPTH = 2048;
  localparam int          AW    = $clog2(DEPTH);
  localparam logic [31:0] NOPW  = 32'h0000_0013;

  logic          clk;
  logic          i_rst;
  logic [31:0]   i_pc;
  logic          i_stall;
  logic          i_flush;
  logic          i_ld_en;
  logic [AW-1:0] i_ld_addr;
  logic [31:0]   i_ld_data;
  logic [31:0]   o_instr;
  logic [31:0]   o_pc;
  logic          o_valid;
  logic [1:0]    o_fault;
  logic [31:0]   o_fetch_cnt;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic [1:0]  fault;
    logic [31:0] cnt;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] mdl_mem [DEPTH];
  bit          mdl_run;
  resp_t       mdl_last;
  int          n_total;
  int          n_pass;

  instr_fetch_resp #(
    .DEPTH_WORDS (DEPTH),
    .NOP         (NOPW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_pc        (i_pc),
    .i_stall     (i_stall),
    .i_flush     (i_flush),
    .i_ld_en     (i_ld_en),
    .i_ld_addr   (i_ld_addr),
    .i_ld_data   (i_ld_data),
    .o_instr     (o_instr),
    .o_pc        (o_pc),
    .o_valid     (o_valid),
    .o_fault     (o_fault),
    .o_fetch_cnt (o_fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic resp_t reset_resp();
    resp_t r;
    r.instr = NOPW;
    r.pc    = 32'd0;
    r.valid = 1'b0;
    r.fault = 2'd0;
    r.cnt   = 32'd0;
    return r;
  endfunction

  function automatic resp_t observed();
    resp_t r;
    r.instr = o_instr;
    r.pc    = o_pc;
    r.valid = o_valid;
    r.fault = o_fault;
    r.cnt   = o_fetch_cnt;
    return r;
  endfunction

  // Drive one cycle of stimulus, predict the response, push it, step one edge.
  task automatic cycle(input logic [31:0] pc, input logic stall, input logic flush,
                       input logic ld_en, input logic [AW-1:0] la, input logic [31:0] ld);
    resp_t r;
    i_pc      = pc;
    i_stall   = stall;
    i_flush   = flush;
    i_ld_en   = ld_en;
    i_ld_addr = la;
    i_ld_data = ld;
    if (!i_rst) begin
      r       = reset_resp();
      mdl_run = 1'b0;
    end else if (!mdl_run) begin
      r       = mdl_last;
      mdl_run = 1'b1;
    end else if (flush) begin
      r       = mdl_last;
      r.instr = NOPW;
      r.pc    = pc;
      r.valid = 1'b0;
      r.fault = 2'd0;
    end else if (stall) begin
      r = mdl_last;
    end else begin
      r.pc    = pc;
      r.valid = 1'b1;
      if (pc[1:0] != 2'b00)          r.fault = 2'd1;
      else if (pc >= 32'(DEPTH * 4)) r.fault = 2'd2;
      else                           r.fault = 2'd0;
      r.instr = (r.fault != 2'd0) ? NOPW : mdl_mem[pc[AW+1:2]];
      r.cnt   = mdl_last.cnt + ((r.fault == 2'd0) ? 32'd1 : 32'd0);
    end
    if (ld_en) mdl_mem[la] = ld;
    mdl_last = r;
    exp_q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resp_t e, o;
    i_rst = 1'b1;
    #1 i_rst = 1'b0;
    #1;
    o = observed(); e = reset_resp(); n_total++;
    if (o !== e) $display("FAIL reset_state: got %h want %h", o, e);
    else n_pass++;
    mdl_run = 1'b0; mdl_last = reset_resp();
    @(posedge clk); #1;
    cycle(32'h0, 1'b0, 1'b0, 1'b1, AW'(0), 32'hAAAA_0001);
    e = exp_q.pop_front(); o = observed(); n_total++;
    if (o !== e) $display("FAIL preload0: got %h want %h", o, e);
    else n_pass++;
    cycle(32'h0, 1'b0, 1'b0, 1'b1, AW'(1), 32'hAAAA_0002);
    e = exp_q.pop_front(); o = observed(); n_total++;
    if (o !== e) $display("FAIL preload1: got %h want %h", o, e);
    else n_pass++;
    i_rst = 1'b1;
  endtask

  task automatic test_first_fetch();
    resp_t e, o;
    logic [31:0] pcs [3];
    pcs[0] = 32'h0; pcs[1] = 32'h0; pcs[2] = 32'h4;
    for (int i = 0; i < 3; i++) begin
      cycle(pcs[i], 1'b0, 1'b0, 1'b0, AW'(0), 32'h0);
      e = exp_q.pop_front(); o = observed(); n_total++;
      if (o !== e) $display("FAIL first_fetch[%0d]: got instr=%h pc=%h vld=%b flt=%0d cnt=%0d want instr=%h pc=%h vld=%b flt=%0d cnt=%0d",
                            i, o.instr, o.pc, o.valid, o.fault, o.cnt, e.instr, e.pc, e.valid, e.fault, e.cnt);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    resp_t e, o;
    for (int i = 0; i < 3; i++) begin
      cycle(32'h8, 1'b1, 1'b0, 1'b0, AW'(0), 32'h0);
      e = exp_q.pop_front(); o = observed(); n_total++;
      if (o !== e) $display("FAIL stall[%0d]: got instr=%h pc=%h vld=%b flt=%0d cnt=%0d want instr=%h pc=%h vld=%b flt=%0d cnt=%0d",
                            i, o.instr, o.pc, o.valid, o.fault, o.cnt, e.instr, e.pc, e.valid, e.fault, e.cnt);
      else n_pass++;
    end
  endtask

  task automatic test_flush();
    resp_t e, o;
    cycle(32'h40, 1'b1, 1'b1, 1'b0, AW'(0), 32'h0);
    e = exp_q.pop_front(); o = observed(); n_total++;
    if (o !== e) $display("FAIL flush_stall: got %h want %h", o, e);
    else n_pass++;
    cycle(32'h0, 1'b0, 1'b0, 1'b0, AW'(0), 32'h0);
    e = exp_q.pop_front(); o = observed(); n_total++;
    if (o !== e) $display("FAIL after_flush: got %h want %h", o, e);
    else n_pass++;
  endtask

  task automatic test_faults();
    resp_t e, o;
    logic [31:0] pcs [5];
    pcs[0] = 32'h6; pcs[1] = 32'(DEPTH * 4); pcs[2] = 32'hFFFF_FFFC;
    pcs[3] = 32'h0000_8001; pcs[4] = 32'h4;
    for (int i = 0; i < 5; i++) begin
      cycle(pcs[i], 1'b0, 1'b0, 1'b0, AW'(0), 32'h0);
      e = exp_q.pop_front(); o = observed(); n_total++;
      if (o !== e) $display("FAIL fault[%0d] pc=%h: got instr=%h flt=%0d cnt=%0d want instr=%h flt=%0d cnt=%0d",
                            i, pcs[i], o.instr, o.fault, o.cnt, e.instr, e.fault, e.cnt);
      else n_pass++;
    end
  endtask

  task automatic test_load_collision();
    resp_t e, o;
    cycle(32'h0, 1'b0, 1'b0, 1'b1, AW'(5), 32'hDEAD_0005);
    e = exp_q.pop_front(); o = observed(); n_total++;
    if (o !== e) $display("FAIL load_old_word5: got %h want %h", o, e);
    else n_pass++;
    cycle(32'h14, 1'b0, 1'b0, 1'b1, AW'(5), 32'h1234_5678);
    e = exp_q.pop_front(); o = observed(); n_total++;
    if (o !== e) $display("FAIL collision_old: got instr=%h want %h", o.instr, e.instr);
    else n_pass++;
    cycle(32'h14, 1'b0, 1'b0, 1'b0, AW'(0), 32'h0);
    e = exp_q.pop_front(); o = observed(); n_total++;
    if (o !== e) $display("FAIL refetch_new: got instr=%h want %h", o.instr, e.instr);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    resp_t e, o;
    for (int i = 0; i < 4; i++) begin
      cycle(32'h0, 1'b0, 1'b0, 1'b1, AW'(8 + i), 32'hB0B0_0000 + 32'(i));
      e = exp_q.pop_front(); o = observed(); n_total++;
      if (o !== e) $display("FAIL b2b_load[%0d]: got %h want %h", i, o, e);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      cycle(32'h20 + 32'(4 * i), 1'b0, 1'b0, 1'b0, AW'(0), 32'h0);
      e = exp_q.pop_front(); o = observed(); n_total++;
      if (o !== e) $display("FAIL b2b_fetch[%0d]: got instr=%h pc=%h cnt=%0d want instr=%h pc=%h cnt=%0d",
                            i, o.instr, o.pc, o.cnt, e.instr, e.pc, e.cnt);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    resp_t e, o;
    cycle(32'h20, 1'b0, 1'b0, 1'b0, AW'(0), 32'h0);
    e = exp_q.pop_front(); o = observed(); n_total++;
    if (o !== e) $display("FAIL pre_reset: got %h want %h", o, e);
    else n_pass++;
    #2 i_rst = 1'b0;
    #1;
    o = observed(); e = reset_resp(); n_total++;
    if (o !== e) $display("FAIL async_reset: got %h want %h", o, e);
    else n_pass++;
    cycle(32'h20, 1'b0, 1'b0, 1'b0, AW'(0), 32'h0);
    e = exp_q.pop_front(); o = observed(); n_total++;
    if (o !== e) $display("FAIL in_reset: got %h want %h", o, e);
    else n_pass++;
    i_rst = 1'b1;
    cycle(32'h24, 1'b0, 1'b1, 1'b0, AW'(0), 32'h0);
    e = exp_q.pop_front(); o = observed(); n_total++;
    if (o !== e) $display("FAIL boot_flush: got %h want %h", o, e);
    else n_pass++;
    cycle(32'h24, 1'b0, 1'b0, 1'b0, AW'(0), 32'h0);
    e = exp_q.pop_front(); o = observed(); n_total++;
    if (o !== e) $display("FAIL post_reset: got instr=%h pc=%h cnt=%0d want instr=%h pc=%h cnt=%0d",
                          o.instr, o.pc, o.cnt, e.instr, e.pc, e.cnt);
    else n_pass++;
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    i_rst     = 1'b1;
    i_pc      = 32'h0;
    i_stall   = 1'b0;
    i_flush   = 1'b0;
    i_ld_en   = 1'b0;
    i_ld_addr = '0;
    i_ld_data = 32'h0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_flush();
    test_faults();
    test_load_collision();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
